// File: rtl/gobang_move_ctrl.sv
// Gobang move controller: turns keyboard press/release events into cursor
// moves (with auto-repeat on held direction keys) and, on confirm, runs a
// read-check-write sequence against the board RAM before handing the turn
// to the other player.
module gobang_move_ctrl #(
    parameter int BOARD_SIZE   = 15,
    parameter int REPEAT_START = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       key_state,
    input  logic [4:0] key_ctrl,
    input  logic       game_en,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       cur_player,
    output logic [7:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [1:0] wr_data,
    input  logic       wr_ack,
    output logic       move_done,
    output logic       reject
);

    localparam int         CNT_MAX = (REPEAT_START > REPEAT_RATE) ? REPEAT_START : REPEAT_RATE;
    localparam int         CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [3:0] LAST    = 4'(BOARD_SIZE - 1);
    localparam logic [3:0] HOME    = 4'd7;

    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;
    typedef enum logic [2:0] {K_NONE, K_CONF, K_UP, K_DOWN, K_LEFT, K_RIGHT} key_t;

    // key_ctrl = {confirm, right, left, down, up}; confirm wins, then up..right
    function automatic key_t decode_key(input logic [4:0] k);
        if (k[4])      return K_CONF;
        else if (k[0]) return K_UP;
        else if (k[1]) return K_DOWN;
        else if (k[2]) return K_LEFT;
        else if (k[3]) return K_RIGHT;
        else           return K_NONE;
    endfunction

    function automatic logic is_dir(input key_t k);
        return (k == K_UP) || (k == K_DOWN) || (k == K_LEFT) || (k == K_RIGHT);
    endfunction

    state_t             state, state_nxt;
    key_t               press_key, held_key, move_key;
    logic               key_state_d;
    logic               press;
    logic               rep_fire;
    logic               rep_phase;
    logic [CNT_W-1:0]   rep_cnt;
    logic               idle_ready;
    logic [3:0]         x_nxt, y_nxt;

    assign rd_addr   = 8'(cursor_y) * 8'(BOARD_SIZE) + 8'(cursor_x);
    assign wr_en     = (state == WRITE);
    assign move_done = (state == DONE);

    // Press detection, repeat timing and which key may act this cycle.
    // The reject cycle is treated as busy so a new key can't race the pulse.
    always_comb begin
        press      = key_state & ~key_state_d;
        press_key  = press ? decode_key(key_ctrl) : K_NONE;
        rep_fire   = key_state && !press && is_dir(held_key) &&
                     (rep_phase ? (rep_cnt == CNT_W'(REPEAT_RATE - 1))
                                : (rep_cnt == CNT_W'(REPEAT_START - 1)));
        idle_ready = (state == IDLE) && !reject && game_en;
        move_key   = K_NONE;
        if (idle_ready) begin
            if (is_dir(press_key)) move_key = press_key;
            else if (rep_fire)     move_key = held_key;
        end
    end

    // Next cursor position with wrap-around at both board edges
    always_comb begin
        x_nxt = cursor_x;
        y_nxt = cursor_y;
        case (move_key)
            K_UP:    y_nxt = (cursor_y == 4'd0) ? LAST : cursor_y - 4'd1;
            K_DOWN:  y_nxt = (cursor_y == LAST) ? 4'd0 : cursor_y + 4'd1;
            K_LEFT:  x_nxt = (cursor_x == 4'd0) ? LAST : cursor_x - 4'd1;
            K_RIGHT: x_nxt = (cursor_x == LAST) ? 4'd0 : cursor_x + 4'd1;
            default: ;
        endcase
    end

    // Confirm sequencing: read square, check it, write stone, finish turn
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (idle_ready && press_key == K_CONF) state_nxt = READ;
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = (rd_data == 2'b00) ? WRITE : IDLE;
            WRITE:   if (wr_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered key level for edge detection
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) key_state_d <= 1'b0;
        else           key_state_d <= key_state;
    end

    // Auto-repeat counter: first period REPEAT_START, then REPEAT_RATE
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            held_key  <= K_NONE;
        end else if (!key_state) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            held_key  <= K_NONE;
        end else if (press) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            held_key  <= is_dir(press_key) ? press_key : K_NONE;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else if (is_dir(held_key)) begin
            rep_cnt   <= rep_cnt + CNT_W'(1);
        end
    end

    // Cursor register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cursor_x <= HOME;
            cursor_y <= HOME;
        end else begin
            cursor_x <= x_nxt;
            cursor_y <= y_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    // Write request payload, reject pulse and turn hand-over
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_addr    <= 8'd0;
            wr_data    <= 2'b00;
            reject     <= 1'b0;
            cur_player <= 1'b0;
        end else begin
            reject <= (state == CHECK) && (rd_data != 2'b00);
            if (state == CHECK && rd_data == 2'b00) begin
                wr_addr <= rd_addr;
                wr_data <= cur_player ? 2'b10 : 2'b01;
            end
            if (state == DONE) cur_player <= ~cur_player;
        end
    end

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Directed bench for gobang_move_ctrl: table of cursor presses plus
// hand-written confirm / reject / auto-repeat / reset sequences.
module tb_gobang_move_ctrl;

    localparam int BS = 15;
    localparam int RS = 10;
    localparam int RR = 4;

    localparam logic [4:0] K_UP    = 5'b00001;
    localparam logic [4:0] K_DOWN  = 5'b00010;
    localparam logic [4:0] K_LEFT  = 5'b00100;
    localparam logic [4:0] K_RIGHT = 5'b01000;
    localparam logic [4:0] K_CONF  = 5'b10000;

    logic       clk_in    = 1'b0;
    logic       rst_n_in  = 1'b0;
    logic       key_state = 1'b0;
    logic [4:0] key_ctrl  = 5'b0;
    logic       game_en   = 1'b1;
    logic       wr_ack    = 1'b0;
    logic [1:0] rd_data   = 2'b00;
    logic [3:0] cursor_x, cursor_y;
    logic       cur_player, wr_en, move_done, reject;
    logic [7:0] rd_addr, wr_addr;
    logic [1:0] wr_data;

    logic [1:0] board [0:255] = '{default: 2'b00};

    int n_chk  = 0;
    int n_fail = 0;

    gobang_move_ctrl #(.BOARD_SIZE(BS), .REPEAT_START(RS), .REPEAT_RATE(RR)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .key_state(key_state), .key_ctrl(key_ctrl),
        .game_en(game_en), .cursor_x(cursor_x), .cursor_y(cursor_y), .cur_player(cur_player),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .move_done(move_done), .reject(reject)
    );

    always #5 clk_in = ~clk_in;

    // Board RAM: one-cycle read latency, write on wr_en && wr_ack
    always @(posedge clk_in) begin
        rd_data <= board[rd_addr];
        if (wr_en && wr_ack) board[wr_addr] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic tap(input logic [4:0] k);
        key_ctrl = k; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0; tick;
    endtask

    typedef struct {
        logic [4:0] ctrl;
        logic       en;
        int         n;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vecs [16];
    int   xs [23];

    initial begin
        vecs[0]  = '{K_UP,    1'b1, 7, 7,  0};
        vecs[1]  = '{K_UP,    1'b1, 1, 7,  14};
        vecs[2]  = '{K_DOWN,  1'b1, 1, 7,  0};
        vecs[3]  = '{K_RIGHT, 1'b1, 7, 14, 0};
        vecs[4]  = '{K_DOWN,  1'b1, 3, 14, 3};
        vecs[5]  = '{K_RIGHT, 1'b1, 1, 0,  3};
        vecs[6]  = '{K_LEFT,  1'b1, 1, 14, 3};
        vecs[7]  = '{5'b00111,1'b1, 1, 14, 2};
        vecs[8]  = '{5'b01100,1'b1, 1, 13, 2};
        vecs[9]  = '{5'b00000,1'b1, 1, 13, 2};
        vecs[10] = '{K_UP,    1'b0, 1, 13, 2};
        vecs[11] = '{5'b01010,1'b1, 1, 13, 3};
        vecs[12] = '{K_UP,    1'b1, 4, 13, 14};
        vecs[13] = '{K_DOWN,  1'b1, 1, 13, 0};
        vecs[14] = '{K_LEFT,  1'b1, 6, 7,  0};
        vecs[15] = '{K_DOWN,  1'b1, 7, 7,  7};

        // reset state, while asserted and after release
        tick; tick;
        chk("rst_x", cursor_x, 7);
        chk("rst_y", cursor_y, 7);
        chk("rst_player", cur_player, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_move_done", move_done, 0);
        chk("rst_reject", reject, 0);
        rst_n_in = 1'b1;
        tick;
        chk("rel_rd_addr", rd_addr, 112);
        chk("rel_x", cursor_x, 7);

        // cursor moves: check lands on the cycle right after the press edge
        for (int i = 0; i < 16; i++) begin
            game_en = vecs[i].en;
            for (int j = 0; j < vecs[i].n; j++) begin
                key_ctrl = vecs[i].ctrl; key_state = 1'b1;
                tick;
                if (j == vecs[i].n - 1) begin
                    chk($sformatf("vec%0d_x", i), cursor_x, vecs[i].ex);
                    chk($sformatf("vec%0d_y", i), cursor_y, vecs[i].ey);
                    chk($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].ey * BS + vecs[i].ex);
                end
                key_ctrl = 5'b0; key_state = 1'b0;
                tick;
            end
            game_en = 1'b1;
        end

        // confirm at (7,7), ack delayed: wr_en high 4 cycles; right press in WRITE dropped
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        chk("c1_read_wr_en", wr_en, 0);
        key_ctrl = 5'b0; key_state = 1'b0; tick;
        chk("c1_check_wr_en", wr_en, 0);
        tick;
        chk("c1_wr_addr", wr_addr, 112);
        chk("c1_wr_data", wr_data, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c1_wr_en_%0d", i), wr_en, 1);
            chk($sformatf("c1_md_low_%0d", i), move_done, 0);
            if (i == 1) begin key_ctrl = K_RIGHT; key_state = 1'b1; end
            if (i == 2) begin key_ctrl = 5'b0; key_state = 1'b0; end
            if (i == 3) wr_ack = 1'b1;
            tick;
        end
        wr_ack = 1'b0;
        chk("c1_done_wr_en", wr_en, 0);
        chk("c1_move_done", move_done, 1);
        chk("c1_player_hold", cur_player, 0);
        chk("c1_frozen_x", cursor_x, 7);
        tick;
        chk("c1_md_end", move_done, 0);
        chk("c1_player", cur_player, 1);
        chk("c1_board", board[112], 1);

        // second move at (8,7) with immediate ack writes white
        tap(K_RIGHT);
        chk("c2_x", cursor_x, 8);
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0; tick;
        tick;
        chk("c2_wr_en", wr_en, 1);
        chk("c2_wr_addr", wr_addr, 113);
        chk("c2_wr_data", wr_data, 2);
        wr_ack = 1'b1; tick; wr_ack = 1'b0;
        chk("c2_move_done", move_done, 1);
        tick;
        chk("c2_player", cur_player, 0);
        chk("c2_board", board[113], 2);

        // confirm on occupied (7,7): reject pulse only
        tap(K_LEFT);
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0; tick;
        chk("rj_check_wr_en", wr_en, 0);
        tick;
        chk("rj_reject", reject, 1);
        chk("rj_wr_en", wr_en, 0);
        tick;
        chk("rj_reject_end", reject, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rj_no_wr_%0d", i), wr_en, 0);
            tick;
        end
        chk("rj_player", cur_player, 0);

        // confirm with game_en=0 ignored
        game_en = 1'b0;
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("ge_no_wr_%0d", i), wr_en, 0);
        end
        game_en = 1'b1;
        chk("ge_player", cur_player, 0);

        // auto-repeat: hold left 23 edges from x=5
        tap(K_LEFT); tap(K_LEFT);
        chk("ar_start_x", cursor_x, 5);
        key_ctrl = K_LEFT; key_state = 1'b1;
        for (int k = 0; k < 23; k++) begin
            tick;
            xs[k] = int'(cursor_x);
        end
        key_ctrl = 5'b0; key_state = 1'b0;
        chk("ar_e0",  xs[0],  4);
        chk("ar_e9",  xs[9],  4);
        chk("ar_e10", xs[10], 3);
        chk("ar_e13", xs[13], 3);
        chk("ar_e14", xs[14], 2);
        chk("ar_e17", xs[17], 2);
        chk("ar_e18", xs[18], 1);
        chk("ar_e21", xs[21], 1);
        chk("ar_e22", xs[22], 0);
        for (int k = 0; k < 10; k++) tick;
        chk("ar_release_x", cursor_x, 0);
        chk("ar_y", cursor_y, 7);

        // move at (0,7) so white is to play, then reset in WRITE at (1,7)
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0; tick; tick;
        chk("c3_wr_addr", wr_addr, 105);
        wr_ack = 1'b1; tick; wr_ack = 1'b0; tick;
        chk("c3_player", cur_player, 1);
        tap(K_RIGHT);
        key_ctrl = K_CONF; key_state = 1'b1; tick;
        key_ctrl = 5'b0; key_state = 1'b0; tick; tick;
        chk("c4_wr_en", wr_en, 1);
        chk("c4_wr_data", wr_data, 2);
        #2 rst_n_in = 1'b0;
        #1;
        chk("ar_rst_wr_en", wr_en, 0);
        chk("ar_rst_x", cursor_x, 7);
        chk("ar_rst_y", cursor_y, 7);
        chk("ar_rst_player", cur_player, 0);
        chk("ar_rst_wr_addr", wr_addr, 0);
        chk("ar_rst_wr_data", wr_data, 0);
        tick; tick;
        rst_n_in = 1'b1;
        tick; tick;
        chk("ar_rst_no_write", board[106], 0);
        chk("ar_rst_idle_wr_en", wr_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
